// File: rtl/sha512_arbiter_if.sv
// Bundle of requester-side and core-side signals around the sha512 arbiter.
// The arbiter connects through the slave modport; the requester/core side
// (stream engines plus uu_sha512) connects through the master modport.
//
// Handshake: a block moves from requester i into the arbiter on every cycle
// where req_block_valid[i] and req_block_ready[i] are both high. Ready for i
// is raised only while i holds the grant and the core can take a block, and
// it may depend combinationally on req_block_valid[i] and core_ready.
// core_block_valid, req_digest_valid and core_digest_valid are single-cycle
// pulses with no back-pressure; their data buses are sampled only while the
// pulse is high.
interface sha512_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int BLOCK_W  = 1024,
  parameter int DIGEST_W = 512
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0][BLOCK_W-1:0] req_block;
  logic [N_REQ-1:0]              req_block_valid;
  logic [N_REQ-1:0]              req_last;
  logic [N_REQ-1:0]              req_block_ready;
  logic [N_REQ-1:0]              req_digest_valid;
  logic [DIGEST_W-1:0]           digest_out;
  logic [BLOCK_W-1:0]            core_block;
  logic                          core_block_valid;
  logic                          core_first;
  logic                          core_ready;
  logic [DIGEST_W-1:0]           core_digest;
  logic                          core_digest_valid;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic [N_REQ-1:0][15:0]        msg_count;

  modport master (
    output req_block, req_block_valid, req_last, core_ready, core_digest,
           core_digest_valid,
    input  req_block_ready, req_digest_valid, digest_out, core_block,
           core_block_valid, core_first, grant_id, busy, msg_count
  );

  modport slave (
    input  req_block, req_block_valid, req_last, core_ready, core_digest,
           core_digest_valid,
    output req_block_ready, req_digest_valid, digest_out, core_block,
           core_block_valid, core_first, grant_id, busy, msg_count
  );
endinterface

// File: rtl/sha512_arbiter.sv
// Round-robin arbiter sharing one sha512 core between N_REQ requesters.
// A grant lasts a whole message: blocks are fed one at a time, the first block
// of each message is flagged so the core reloads its IV, and the digest of the
// final block is routed back to the owner together with a completion count.
module sha512_arbiter #(
  parameter int N_REQ    = 4,
  parameter int BLOCK_W  = 1024,
  parameter int DIGEST_W = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  sha512_arbiter_if.slave      bus,
  output logic [1:0]           stateDbg
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                 stateQ, stateD;
  logic [GW-1:0]          rrQ, grantQ;
  logic                   firstPendingQ, lastPendingQ;
  logic [BLOCK_W-1:0]     coreBlockQ;
  logic                   coreValidQ, coreFirstQ;
  logic [DIGEST_W-1:0]    digestQ;
  logic [N_REQ-1:0]       digValidQ;
  logic [N_REQ-1:0][15:0] msgCountQ;

  logic                   hit;
  logic [GW-1:0]          winner;
  logic [GW-1:0]          winnerNext;
  int                     scanIdx;
  logic                   accept;

  // Scan requesters starting at the round-robin pointer; first valid wins.
  always_comb begin
    hit     = 1'b0;
    winner  = rrQ;
    scanIdx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scanIdx = (int'(rrQ) + i) % N_REQ;
      if (!hit && bus.req_block_valid[scanIdx]) begin
        hit    = 1'b1;
        winner = GW'(scanIdx);
      end
    end
  end

  assign winnerNext = (winner == GW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign accept     = (stateQ == ISSUE) && bus.core_ready && bus.req_block_valid[grantQ];

  // Only the current owner sees ready, and only while a block can move.
  always_comb begin
    bus.req_block_ready = '0;
    if (accept) bus.req_block_ready[grantQ] = 1'b1;
  end

  // Next-state selection for the message sequencer.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (hit) stateD = ISSUE;
      ISSUE:   if (accept) stateD = BUSY;
      BUSY:    if (bus.core_digest_valid) stateD = lastPendingQ ? IDLE : ISSUE;
      default: stateD = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Grant, block capture, digest return and per-requester completion counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrQ           <= '0;
      grantQ        <= '0;
      firstPendingQ <= 1'b0;
      lastPendingQ  <= 1'b0;
      coreBlockQ    <= '0;
      coreValidQ    <= 1'b0;
      coreFirstQ    <= 1'b0;
      digestQ       <= '0;
      digValidQ     <= '0;
      msgCountQ     <= '0;
    end else begin
      coreValidQ <= 1'b0;
      coreFirstQ <= 1'b0;
      digValidQ  <= '0;
      case (stateQ)
        IDLE: begin
          if (hit) begin
            grantQ        <= winner;
            rrQ           <= winnerNext;
            firstPendingQ <= 1'b1;
          end
        end
        ISSUE: begin
          if (accept) begin
            coreBlockQ    <= bus.req_block[grantQ];
            coreValidQ    <= 1'b1;
            coreFirstQ    <= firstPendingQ;
            lastPendingQ  <= bus.req_last[grantQ];
            firstPendingQ <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.core_digest_valid && lastPendingQ) begin
            digestQ           <= bus.core_digest;
            digValidQ[grantQ] <= 1'b1;
            msgCountQ[grantQ] <= msgCountQ[grantQ] + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.core_block       = coreBlockQ;
  assign bus.core_block_valid = coreValidQ;
  assign bus.core_first       = coreFirstQ;
  assign bus.digest_out       = digestQ;
  assign bus.req_digest_valid = digValidQ;
  assign bus.grant_id         = grantQ;
  assign bus.busy             = (stateQ != IDLE);
  assign bus.msg_count        = msgCountQ;
  assign stateDbg             = stateQ;
endmodule
